// File: rtl/piso_shift_reg.sv
// -----------------------------------------------------------------------------
// piso_shift_reg
//
// Parallel-in / serial-out shift register. A parallel word is captured on the
// preload strobe and then shifted out MSB first, one bit per clock. New bits
// enter at the LSB end from the serial input, so several instances can be
// chained through sdi/sdo.
//
// Parameters:
//   WIDTH  register width in bits (>= 2)
//
// Ports:
//   clk    input   1      rising-edge clock
//   reset  input   1      synchronous, active-high reset (clears the register)
//   sdi    input   1      serial data in, enters bit 0 on every shift
//   pl     input   1      preload strobe, loads d instead of shifting
//   d      input   WIDTH  parallel load data
//   sdo    output  1      serial data out, the register MSB
// -----------------------------------------------------------------------------
module piso_shift_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sdi,
    input  logic             pl,
    input  logic [WIDTH-1:0] d,
    output logic             sdo
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    // Next-state selection: a load wins over the shift it coincides with,
    // so the bit that would have left on that edge is dropped.
    always_comb begin
        q_d = q_q;
        if (pl) begin
            q_d = d;
        end else begin
            q_d = {q_q[WIDTH-2:0], sdi};
        end
    end

    // State register with synchronous reset taking priority over any load.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= {WIDTH{1'b0}};
        end else begin
            q_q <= q_d;
        end
    end

    // The MSB is already a flop, so sdo needs no extra output stage; a
    // loaded word's MSB is visible immediately after the load edge.
    assign sdo = q_q[WIDTH-1];

endmodule

// File: tb/tb_piso_shift_reg.sv
module tb_piso_shift_reg;

    localparam int WIDTH = 4;

    logic             clk;
    logic             reset;
    logic             sdi;
    logic             pl;
    logic [WIDTH-1:0] d;
    logic             sdo;

    int total_cnt;
    int bad_cnt;

    piso_shift_reg #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .sdi   (sdi),
        .pl    (pl),
        .d     (d),
        .sdo   (sdo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic check_val(input string tag, input logic obs, input logic exp);
        total_cnt = total_cnt + 1;
        if (obs !== exp) begin
            bad_cnt = bad_cnt + 1;
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    // Drive inputs for one edge, let the edge happen, then check sdo 1 ns later.
    task automatic step(input logic rst_v, input logic pl_v, input logic [WIDTH-1:0] d_v,
                        input logic sdi_v, input logic exp_sdo, input string tag);
        reset = rst_v;
        pl    = pl_v;
        d     = d_v;
        sdi   = sdi_v;
        @(posedge clk);
        #1;
        check_val(tag, sdo, exp_sdo);
    endtask

    initial begin
        total_cnt = 0;
        bad_cnt   = 0;
        reset = 1'b0;
        pl    = 1'b0;
        d     = 4'b0000;
        sdi   = 1'b0;
        #2;

        // 1. Reset dominates a simultaneous preload of all ones.
        step(1'b1, 1'b1, 4'b1111, 1'b0, 1'b0, "rst_pri_e1");
        step(1'b1, 1'b1, 4'b1111, 1'b0, 1'b0, "rst_pri_e2");

        // 2. Load 0101 then shift out MSB first with sdi=0.
        step(1'b0, 1'b1, 4'b0101, 1'b0, 1'b0, "ld0101_k0");
        step(1'b0, 1'b0, 4'b1111, 1'b0, 1'b1, "ld0101_k1");
        step(1'b0, 1'b0, 4'b1111, 1'b0, 1'b0, "ld0101_k2");
        step(1'b0, 1'b0, 4'b1111, 1'b0, 1'b1, "ld0101_k3");
        step(1'b0, 1'b0, 4'b1111, 1'b0, 1'b0, "ld0101_k4");
        step(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, "ld0101_empty");

        // 3. Serial fill: a single 1 on sdi shows on sdo after the 4th edge.
        step(1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, "fill_rst");
        step(1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, "fill_e1");
        step(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, "fill_e2");
        step(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, "fill_e3");
        step(1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, "fill_e4");
        step(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, "fill_e5");

        // 4. Reload in the middle of a word discards the rest of it.
        step(1'b0, 1'b1, 4'b1100, 1'b0, 1'b1, "reld_a0");
        step(1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, "reld_a1");
        step(1'b0, 1'b1, 4'b0011, 1'b0, 1'b0, "reld_b0");
        step(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, "reld_b1");
        step(1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, "reld_b2");
        step(1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, "reld_b3");
        step(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, "reld_b4");

        // 5. Reset mid-shift clears the remaining bits.
        step(1'b0, 1'b1, 4'b1011, 1'b0, 1'b1, "midrst_ld");
        step(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, "midrst_sh1");
        step(1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, "midrst_rst");
        step(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, "midrst_after1");
        step(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, "midrst_after2");
        step(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, "midrst_after3");

        // 6. Held preload: sdo follows d[3] each edge.
        step(1'b0, 1'b1, 4'b1000, 1'b0, 1'b1, "hold_d1000");
        step(1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, "hold_d0000");
        step(1'b0, 1'b1, 4'b1111, 1'b0, 1'b1, "hold_d1111");
        // After releasing pl, 1111 shifts with sdi=0: 1,1,1,0.
        step(1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, "hold_sh1");
        step(1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, "hold_sh2");
        step(1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, "hold_sh3");
        step(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, "hold_sh4");

        // 7. sdi pattern 1,0,1,1 reappears on sdo delayed by WIDTH-1 edges.
        step(1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, "pat_e1");
        step(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, "pat_e2");
        step(1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, "pat_e3");
        step(1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, "pat_e4");
        step(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, "pat_e5");
        step(1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, "pat_e6");
        step(1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, "pat_e7");
        step(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, "pat_e8");

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
